io_write_arbiter: RTL

Shares the eight output ports (one-hot `io_ena` strobes plus an 8-bit data bus, as driven into the `latch_buffer` instances) between two writers: requester A (the CPU) and requester B (a debug/monitor master). Each requester has a small FIFO; a round-robin arbiter drains the FIFOs and issues at most one registered, single-cycle port write per clock. The arbiter sits between the writers and the output latches, so the LD/buzzer and display latches see one well-formed write stream.

---
 rtl/io_write_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/io_write_arbiter.sv
// Two-requester write arbiter: per-requester FIFOs drained round-robin into a
// registered one-hot port strobe plus data bus feeding the output latches.
module io_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [2:0]    a_addr,
  input  logic [7:0]    a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [2:0]    b_addr,
  input  logic [7:0]    b_data,
  output logic [7:0]    io_ena,
  output logic [7:0]    io_data,
  output logic [CW-1:0] a_level,
  output logic [CW-1:0] b_level,
  output logic          busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 11;
  localparam logic [0:0] PRIO_A = 1'b0;
  localparam logic [0:0] PRIO_B = 1'b1;

  logic [EW-1:0] mem_a [DEPTH];
  logic [EW-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_a, rd_a, wr_b, rd_b;
  logic [0:0]    prio;

  logic          push_a, push_b, grant_a, grant_b;
  logic [EW-1:0] head;
  logic [CW-1:0] a_level_nxt, b_level_nxt;
  logic [7:0]    io_ena_nxt, io_data_nxt;

  // Arbitration and next-state computed only from registered FIFO state.
  always_comb begin
    push_a      = a_valid & a_ready;
    push_b      = b_valid & b_ready;
    grant_a     = (a_level != '0) & ((b_level == '0) | (prio == PRIO_A));
    grant_b     = (b_level != '0) & ((a_level == '0) | (prio == PRIO_B));
    head        = grant_a ? mem_a[rd_a] : mem_b[rd_b];
    a_level_nxt = a_level;
    b_level_nxt = b_level;
    io_ena_nxt  = '0;
    io_data_nxt = io_data;

    if (push_a && !grant_a)      a_level_nxt = a_level + CW'(1);
    else if (!push_a && grant_a) a_level_nxt = a_level - CW'(1);

    if (push_b && !grant_b)      b_level_nxt = b_level + CW'(1);
    else if (!push_b && grant_b) b_level_nxt = b_level - CW'(1);

    if (grant_a || grant_b) begin
      io_ena_nxt  = 8'b1 << head[10:8];
      io_data_nxt = head[7:0];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_a    <= '0;
      rd_a    <= '0;
      wr_b    <= '0;
      rd_b    <= '0;
      a_level <= '0;
      b_level <= '0;
      a_ready <= 1'b1;
      b_ready <= 1'b1;
      prio    <= PRIO_A;
      io_ena  <= '0;
      io_data <= '0;
      busy    <= 1'b0;
    end else begin
      if (push_a)  wr_a <= wr_a + AW'(1);
      if (grant_a) rd_a <= rd_a + AW'(1);
      if (push_b)  wr_b <= wr_b + AW'(1);
      if (grant_b) rd_b <= rd_b + AW'(1);
      a_level <= a_level_nxt;
      b_level <= b_level_nxt;
      // ready is a pure function of the registered level, kept as a flop
      a_ready <= (a_level_nxt != CW'(DEPTH));
      b_ready <= (b_level_nxt != CW'(DEPTH));
      if (grant_a)      prio <= PRIO_B;
      else if (grant_b) prio <= PRIO_A;
      io_ena  <= io_ena_nxt;
      io_data <= io_data_nxt;
      busy    <= (a_level_nxt != '0) | (b_level_nxt != '0) | (io_ena_nxt != '0);
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge Clock) begin
    if (push_a) mem_a[wr_a] <= {a_addr, a_data};
    if (push_b) mem_b[wr_b] <= {b_addr, b_data};
  end

endmodule
